display_scan_controller: RTL and testbench

Sequencing controller for the three-digit decimal display path. It accepts a 10-bit binary value on a load strobe and converts it to BCD with an iterative shift-add-3 engine, one bit per clock. It then time-multiplexes the three digits onto a single BCD digit bus and drives active-low digit enables and a 2-bit scan select. It replaces free-running division-based digit extraction with a registered, frame-consistent value and an explicit busy handshake.

---
 rtl/display_scan_controller.sv | 125 ++++++++++++
 tb/tb_display_scan_controller.sv | 135 +++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Three-digit display sequencer: iterative shift-add-3 binary-to-BCD conversion on Load,
// then time-multiplexed digit scan with active-low enables and optional leading-zero blanking.
module display_scan_controller #(
    parameter int SCAN_DIV = 50000,
    parameter bit LZB      = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [9:0] Data,
    input  logic       Load,
    output logic       Busy,
    output logic       Overflow,
    output logic [1:0] SEL,
    output logic [3:0] AN,
    output logic [3:0] Digit,
    output logic       Blank
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state_q;
    logic [9:0]    shreg_q;
    logic [11:0]   bcd_q;
    logic [3:0]    cnt_q;
    logic          busy_q;
    logic          ovf_q;
    logic [3:0]    hund_q, tens_q, ones_q;
    logic [PW-1:0] presc_q;
    logic [1:0]    sel_q;

    logic [11:0]   bcd_adj;
    logic [21:0]   shifted_d;
    logic [9:0]    data_sat;

    assign data_sat = (Data > 10'd999) ? 10'd999 : Data;

    // One double-dabble iteration: correct every nibble >= 5, then shift {BCD, binary} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        shifted_d = {bcd_adj, shreg_q} << 1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            shreg_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Load) begin
                        shreg_q <= data_sat;
                        ovf_q   <= (Data > 10'd999);
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q   <= shifted_d[21:10];
                    shreg_q <= shifted_d[9:0];
                    cnt_q   <= cnt_q + 4'd1;
                    // Display registers are written only here, so a frame never shows a partial value.
                    if (cnt_q == 4'd9) begin
                        hund_q  <= shifted_d[21:18];
                        tens_q  <= shifted_d[17:14];
                        ones_q  <= shifted_d[13:10];
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q <= '0;
            sel_q   <= '0;
        end else if (presc_q == PMAX) begin
            presc_q <= '0;
            sel_q   <= sel_q + 2'd1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    always_comb begin
        Digit = '0;
        Blank = 1'b0;
        case (sel_q)
            2'd0: Digit = ones_q;
            2'd1: begin
                Digit = tens_q;
                Blank = LZB && (hund_q == 4'd0) && (tens_q == 4'd0);
            end
            2'd2: begin
                Digit = hund_q;
                Blank = LZB && (hund_q == 4'd0);
            end
            default: Blank = 1'b1;
        endcase
        AN = Blank ? '1 : ~(4'b0001 << sel_q);
    end

    assign Busy     = busy_q;
    assign Overflow = ovf_q;
    assign SEL      = sel_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: directed scenarios plus random loads/resets, every cycle
// compared against an arithmetic model of value, busy window and scan position.
module tb_display_scan_controller;

    localparam int SD = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Load = 1'b0;
    logic [9:0] Data = '0;

    logic       busy1, ovf1, blk1, busy0, ovf0, blk0;
    logic [1:0] sel1, sel0;
    logic [3:0] an1, dig1, an0, dig0;

    int checks = 0;
    int failures = 0;

    // Model state: displayed value, pending value, remaining busy cycles, edges since reset.
    int m_val = 0, m_pend = 0, m_left = 0, m_cyc = 0;
    bit m_ovf = 1'b0;

    display_scan_controller #(.SCAN_DIV(SD), .LZB(1'b1)) dut_lzb (
        .CLK(CLK), .RST(RST), .Data(Data), .Load(Load),
        .Busy(busy1), .Overflow(ovf1), .SEL(sel1), .AN(an1), .Digit(dig1), .Blank(blk1)
    );

    display_scan_controller #(.SCAN_DIV(SD), .LZB(1'b0)) dut_nolzb (
        .CLK(CLK), .RST(RST), .Data(Data), .Load(Load),
        .Busy(busy0), .Overflow(ovf0), .SEL(sel0), .AN(an0), .Digit(dig0), .Blank(blk0)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge();
        if (RST) begin
            m_val = 0; m_left = 0; m_ovf = 1'b0; m_cyc = 0;
        end else begin
            m_cyc++;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_val = m_pend;
            end else if (Load) begin
                m_pend = (int'(Data) > 999) ? 999 : int'(Data);
                m_ovf  = (int'(Data) > 999);
                m_left = 10;
            end
        end
    endtask

    task automatic check_one(input string nm, input bit lzb, input logic busy, input logic ovf,
                             input logic [1:0] sel, input logic [3:0] an, input logic [3:0] dig,
                             input logic blk);
        int s, o, t, h, d, a;
        bit b;
        s = (m_cyc / SD) % 4;
        o = m_val % 10;
        t = (m_val / 10) % 10;
        h = m_val / 100;
        d = (s == 0) ? o : (s == 1) ? t : (s == 2) ? h : 0;
        b = (s == 3) || (lzb && s == 2 && h == 0) || (lzb && s == 1 && h == 0 && t == 0);
        a = b ? 15 : (~(1 << s)) & 15;
        check({nm, ".busy"},  32'(busy), 32'(m_left > 0));
        check({nm, ".ovf"},   32'(ovf),  32'(m_ovf));
        check({nm, ".sel"},   32'(sel),  32'(s));
        check({nm, ".digit"}, 32'(dig),  32'(d));
        check({nm, ".blank"}, 32'(blk),  32'(b));
        check({nm, ".an"},    32'(an),   32'(a));
    endtask

    task automatic step(input bit rst, input bit ld, input int d);
        RST  = rst;
        Load = ld;
        Data = 10'(d);
        @(posedge CLK);
        model_edge();
        #1;
        check_one("lzb1", 1'b1, busy1, ovf1, sel1, an1, dig1, blk1);
        check_one("lzb0", 1'b0, busy0, ovf0, sel0, an0, dig0, blk0);
        RST  = 1'b0;
        Load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
    endtask

    initial begin
        int r;
        @(negedge CLK);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        check("reset.an", 32'(an1), 32'd14);

        step(1'b0, 1'b1, 375);  idle(20);
        step(1'b0, 1'b1, 1023); idle(12);
        check("ovf.set", 32'(ovf1), 32'd1);
        step(1'b0, 1'b1, 42);   idle(16);
        check("ovf.clear", 32'(ovf1), 32'd0);
        step(1'b0, 1'b1, 7);    idle(16);
        step(1'b0, 1'b1, 105);  idle(16);

        // Loads while busy, including the completing edge, must be dropped.
        step(1'b0, 1'b1, 200);  idle(2);
        step(1'b0, 1'b1, 999);  idle(6);
        step(1'b0, 1'b1, 999);  idle(16);

        // Reset on the fifth busy cycle discards the 888 conversion.
        step(1'b0, 1'b1, 512);  idle(12);
        step(1'b0, 1'b1, 888);  idle(4);
        step(1'b1, 1'b0, 0);    idle(16);

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 7));
            case (r)
                0: step(1'b0, 1'b1, int'($urandom_range(0, 1023)));
                1: step(1'b0, 1'b1, int'($urandom_range(990, 1023)));
                2: step(1'b0, 1'b1, int'($urandom_range(0, 12)));
                default: step(($urandom_range(0, 199) == 0), 1'b0, 0);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
